fetch_ctrl: RTL

Fetch sequencer between the program counter, the synchronous instruction ROM and the decode stage.
- Owns the fetch PC and issues at most one ROM read per cycle.
- Tracks the single in-flight read and buffers returned instructions in a small FIFO.
- Presents instructions to decode with a valid/ready handshake, replacing stall/flush wiring with credit-based flow control.
- Handles branch redirects with kill of stale data, and a halt/ack handshake so a loader or debugger can quiesce fetch.

---
 rtl/fetch_ctrl_pkg.sv | 9 +
 rtl/fetch_ctrl_fifo.sv | 61 ++++++
 rtl/fetch_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared constants for the fetch sequencer
package fetch_ctrl_pkg;

    localparam int          INST_W             = 32;
    localparam int          PC_INC             = 4;
    localparam int          DEFAULT_FIFO_DEPTH = 2;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_fifo.sv
// rtl/fetch_ctrl_fifo.sv - synchronous instruction buffer with clear, used by fetch_ctrl
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The parent only issues a read when a slot is guaranteed on return.
    assert property (@(posedge clk) disable iff (rst) !(push && full && !clear));

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer: PC ownership, ROM read issue, redirect/halt, decode handshake
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    output logic [31:0]       id_inst,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              id_ready,
    input  logic              halt_req,
    output logic              halt_ack
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = INST_W + ADDR_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty;
    logic [ENT_W-1:0]  head;
    logic              pop;
    logic              push;
    logic              kill;
    logic              issue;
    logic [CNT_W:0]    occupancy;

    assign id_valid = !rst && !fifo_empty;
    assign pop      = id_valid && id_ready;

    // Credit check: a read is only launched if its data has a guaranteed slot.
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign issue     = !rst && !halt_req && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    assign imem_en   = issue;
    assign imem_addr = redirect_valid ? redirect_pc : fetch_pc;

    // A response landing in a redirect cycle belongs to the old path.
    assign kill = redirect_valid;
    assign push = inflight && !kill;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            inflight    <= 1'b0;
            halt_ack    <= 1'b0;
        end else begin
            inflight <= issue;
            halt_ack <= halt_req && !issue;
            if (issue) begin
                fetch_pc    <= imem_addr + ADDR_W'(PC_INC);
                inflight_pc <= imem_addr;
            end else if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (push),
        .push_data ({imem_rdata, inflight_pc}),
        .pop       (pop),
        .head_data (head),
        .count     (count),
        .empty     (fifo_empty)
    );

    assign id_inst = head[ENT_W-1 -: INST_W];
    assign id_pc   = head[ADDR_W-1:0];

endmodule
